alu_iterative: RTL

- Execute stage that consumes the 4-bit ALU select and the operand-select decisions made by the ALU control decoder.
- Performs the RV32I integer operation on two XLEN operands.
- Logic/arithmetic/compare ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle, to avoid a barrel shifter.
- Valid/ready handshakes on both sides, so the multi-cycle core can stall fetch/decode.

---
 rtl/rv32_pkg.sv | 35 +++
 rtl/alu_shift_step.sv | 26 ++
 rtl/alu_iterative.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by the decoder and the execute stage.
package rv32_pkg;

   localparam int XLEN = 32;

   // 4-bit ALU select produced by the ALU control decoder; 1010-1111 are reserved.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_op_t;

   // RV32I major opcodes (instr[6:0]).
   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_FENCE  = 7'b0001111,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } instr_t;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves a value by 0..SHIFT_STEP bits.
module alu_shift_step #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1,
   parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
   input  logic [XLEN-1:0]  value_i,
   input  logic [AMT_W-1:0] amount_i,
   input  logic             right_i,
   input  logic             arith_i,
   output logic [XLEN-1:0]  value_o
);

   logic signed [XLEN-1:0] value_s;
   assign value_s = value_i;

   // Direction and fill select; the amount never exceeds SHIFT_STEP so this stays narrow.
   always_comb begin
      value_o = value_i << amount_i;
      if (right_i) begin
         if (arith_i) value_o = value_s >>> amount_i;
         else         value_o = value_i >> amount_i;
      end
   end

endmodule

// File: rtl/alu_iterative.sv
// RV32I execute stage: single-cycle logic/arith/compare, iterative shifts,
// valid/ready handshake on both sides with one operation in flight.
module alu_iterative
   import rv32_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      ALU_sel_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o,
   output logic            busy_o
);

   localparam int AMT_W = $clog2(SHIFT_STEP + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state_q;
   logic [XLEN-1:0]  result_q;
   logic             zero_q;
   logic             valid_q;
   logic [XLEN-1:0]  shreg_q, shreg_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             right_q, arith_q;

   alu_op_t          op;
   logic             is_shift;
   logic [4:0]       shamt;
   logic [XLEN-1:0]  alu_res;
   logic [AMT_W-1:0] step_amt;

   logic signed [XLEN-1:0] src1_s, src2_s;

   assign op       = alu_op_t'(ALU_sel_i);
   assign is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   assign shamt    = src2_i[4:0];
   assign src1_s   = src1_i;
   assign src2_s   = src2_i;

   // Single-cycle result; shift entries only matter for shamt=0 (pass src1 through).
   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:  alu_res = src1_i + src2_i;
         ALU_SUB:  alu_res = src1_i - src2_i;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, (src1_s < src2_s)};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
         ALU_XOR:  alu_res = src1_i ^ src2_i;
         ALU_OR:   alu_res = src1_i | src2_i;
         ALU_AND:  alu_res = src1_i & src2_i;
         ALU_SLL, ALU_SRL, ALU_SRA: alu_res = src1_i;
         default:  alu_res = '0;
      endcase
   end

   // Per-cycle shift amount is min(remaining, SHIFT_STEP).
   always_comb begin
      step_amt = AMT_W'(SHIFT_STEP);
      if (cnt_q < 5'(SHIFT_STEP)) step_amt = cnt_q[AMT_W-1:0];
      cnt_d = cnt_q - 5'(step_amt);
   end

   alu_shift_step #(
      .XLEN       (XLEN),
      .SHIFT_STEP (SHIFT_STEP),
      .AMT_W      (AMT_W)
   ) u_shift_step (
      .value_i  (shreg_q),
      .amount_i (step_amt),
      .right_i  (right_q),
      .arith_i  (arith_q),
      .value_o  (shreg_d)
   );

   // Control FSM with registered result, zero flag and valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         right_q  <= 1'b0;
         arith_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_i) begin
                  if (is_shift && (shamt != 5'd0)) begin
                     shreg_q <= src1_i;
                     cnt_q   <= shamt;
                     right_q <= (op != ALU_SLL);
                     arith_q <= (op == ALU_SRA);
                     state_q <= S_SHIFT;
                  end else begin
                     result_q <= alu_res;
                     zero_q   <= (alu_res == '0);
                     valid_q  <= 1'b1;
                     state_q  <= S_DONE;
                  end
               end
            end
            S_SHIFT: begin
               shreg_q <= shreg_d;
               cnt_q   <= cnt_d;
               if (cnt_d == 5'd0) begin
                  result_q <= shreg_d;
                  zero_q   <= (shreg_d == '0);
                  valid_q  <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready_o  = (state_q == S_IDLE);
   assign busy_o   = (state_q != S_IDLE);
   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign zero_o   = zero_q;

endmodule
